// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// frame field constants and default geometry.
package imem_loader_pkg;

  localparam int ADDR_W_DEF     = 8;   // instruction-memory word-address width
  localparam int CNT_W_DEF      = 16;  // word-count field width (two header bytes)
  localparam int BYTES_PER_WORD = 4;   // payload bytes per instruction word
  localparam int HDR_BYTES      = 2;   // LEN_HI, LEN_LO

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic is_rx_state(input loader_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects payload bytes MSB-first into a 32-bit word and keeps the running
// 8-bit payload checksum. word_ready_o flags the byte that completes a word.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o,
  output logic [7:0]  csum_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;

  // Next-state: clear wins over accept; the checksum wraps modulo 256.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
      csum_d  = '0;
    end else if (accept_i) begin
      shift_d = {shift_q[23:0], byte_i};
      idx_d   = idx_q + 2'd1;
      csum_d  = csum_q + byte_i;
    end
  end

  // Register the shift word, byte index and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  assign word_o       = shift_q;
  assign csum_o       = csum_q;
  assign word_ready_o = accept_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Stream-to-instruction-memory loader. Parses a length-prefixed, checksummed
// frame, writes words from address 0 and holds the CPU until the image is good.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_ready depends only on the registered state; rx_valid may drop at any time
// and the loader simply waits without side effects.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output loader_state_e     dbg_state
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic              done_q, done_d;

  logic              accept;
  logic              asm_clear;
  logic              asm_accept;
  logic              word_ready;
  logic [31:0]       word;
  logic [7:0]        csum;
  logic [CNT_W-1:0]  len_full;

  assign accept     = rx_valid && rx_ready;
  assign asm_accept = accept && (state_q == ST_DATA);
  // Word count as it stands once the low header byte is taken.
  assign len_full   = len_q | CNT_W'(rx_data);

  loader_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (asm_clear),
    .accept_i     (asm_accept),
    .byte_i       (rx_data),
    .word_o       (word),
    .word_ready_o (word_ready),
    .csum_o       (csum)
  );

  // Next-state logic: frame parsing, word sequencing and reload handling.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    asm_clear = 1'b0;
    unique case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = CNT_W'({rx_data, 8'h00});
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0 || 32'(len_full) > DEPTH) state_d = ST_ERR;
          else                                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (CNT_W'(widx_q) == len_q - CNT_W'(1)) begin
          state_d = ST_CSUM;
        end else begin
          widx_d  = widx_q + ADDR_W'(1);
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (rx_data == csum) ? ST_RUN : ST_ERR;
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_d   = ST_LEN_HI;
          len_d     = '0;
          widx_d    = '0;
          asm_clear = 1'b1;
        end
      end
      default: state_d = ST_LEN_HI;
    endcase
    done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  // State, length, word index and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LEN_HI;
      len_q   <= '0;
      widx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      done_q  <= done_d;
    end
  end

  assign rx_ready  = is_rx_state(state_q);
  assign im_we     = (state_q == ST_WRITE);
  assign im_addr   = widx_q;
  assign im_wdata  = word;
  assign cpu_hold  = (state_q != ST_RUN);
  assign err       = (state_q == ST_ERR);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, length errors, gaps,
// mid-load reset and reload from RUN.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          reload = 1'b0;
  logic          im_we;
  logic [7:0]    im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  loader_state_e dbg_state;

  int n_checks = 0;
  int n_bad    = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int done_exp = 0;
  int wr_base;

  logic [39:0] exp_q[$];         // {addr, data} of expected writes, in order
  logic [31:0] mem_model[256];   // image as written through the write port
  logic [7:0]  frm[$];

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .reload    (reload),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write cycle is matched against the expected queue.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      wr_cnt++;
      check_eq("wr_rx_ready_low", 64'(rx_ready), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_bad++;
        $display("FAIL wr_unexpected: got=%0h:%0h exp=none", im_addr, im_wdata);
      end else begin
        check_eq("wr_word", 64'({im_addr, im_wdata}), 64'(exp_q.pop_front()));
      end
      mem_model[im_addr] = im_wdata;
    end
    if (rst_n && done) done_cnt++;
  end

  // Drivers: all input changes happen on the falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      n_checks++;
      n_bad++;
      $display("FAIL rx_ready_timeout: got=0 exp=1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frm[i]) send_byte(frm[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic push_good_writes();
    exp_q.push_back({8'd0, 32'h2008_0005});
    exp_q.push_back({8'd1, 32'h0000_0000});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    check_eq({tag, "_im_we"},    64'(im_we),    64'd0);
    check_eq({tag, "_im_addr"},  64'(im_addr),  64'd0);
    check_eq({tag, "_im_wdata"}, 64'(im_wdata), 64'd0);
    check_eq({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check_eq({tag, "_done"},     64'(done),     64'd0);
    check_eq({tag, "_err"},      64'(err),      64'd0);
    check_eq({tag, "_state"},    64'(dbg_state), 64'(ST_LEN_HI));
  endtask

  task automatic check_run(input string tag);
    done_exp++;
    check_eq({tag, "_done_pulse"}, 64'(done),      64'd1);
    check_eq({tag, "_state"},      64'(dbg_state), 64'(ST_RUN));
    check_eq({tag, "_cpu_hold"},   64'(cpu_hold),  64'd0);
    check_eq({tag, "_err"},        64'(err),       64'd0);
    @(negedge clk);
    check_eq({tag, "_done_once"},  64'(done),      64'd0);
    check_eq({tag, "_done_cnt"},   64'(done_cnt),  64'(done_exp));
    check_eq({tag, "_exp_empty"},  64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_err(input string tag);
    check_eq({tag, "_state"},    64'(dbg_state), 64'(ST_ERR));
    check_eq({tag, "_err"},      64'(err),       64'd1);
    check_eq({tag, "_cpu_hold"}, 64'(cpu_hold),  64'd1);
    check_eq({tag, "_rx_ready"}, 64'(rx_ready),  64'd0);
    check_eq({tag, "_done_cnt"}, 64'(done_cnt),  64'(done_exp));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Good 2-word load
    push_good_writes();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    send_frame(0);
    check_run("good");
    check_eq("good_mem0", 64'(mem_model[0]), 64'h2008_0005);
    check_eq("good_mem1", 64'(mem_model[1]), 64'h0000_0000);

    // Reload from RUN, then bad checksum
    pulse_reload();
    check_eq("reload_run_hold",  64'(cpu_hold),  64'd1);
    check_eq("reload_run_state", 64'(dbg_state), 64'(ST_LEN_HI));
    push_good_writes();
    frm[10] = 8'h2E;
    send_frame(0);
    check_err("badsum");
    check_eq("badsum_exp_empty", 64'(exp_q.size()), 64'd0);
    pulse_reload();
    check_eq("reload_err_clear", 64'(err), 64'd0);
    push_good_writes();
    frm[10] = 8'h2D;
    send_frame(0);
    check_run("after_badsum");

    // Length errors: N=0 and N=257
    pulse_reload();
    wr_base = wr_cnt;
    frm = '{8'h00, 8'h00};
    send_frame(0);
    check_err("len0");
    repeat (3) @(negedge clk);
    check_eq("len0_no_write", 64'(wr_cnt), 64'(wr_base));
    pulse_reload();
    frm = '{8'h01, 8'h01};
    send_frame(0);
    check_err("len257");
    repeat (3) @(negedge clk);
    check_eq("len257_no_write", 64'(wr_cnt), 64'(wr_base));
    pulse_reload();

    // Random idle gaps inside words
    push_good_writes();
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
    send_frame(5);
    check_run("gaps");
    check_eq("gaps_mem0", 64'(mem_model[0]), 64'h2008_0005);
    check_eq("gaps_mem1", 64'(mem_model[1]), 64'h0000_0000);

    // Asynchronous reset after the 6th byte (first word written)
    pulse_reload();
    exp_q.push_back({8'd0, 32'h2008_0005});
    for (int i = 0; i < 6; i++) send_byte(frm[i], 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check_eq("midreset_exp_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_good_writes();
    send_frame(0);
    check_run("after_reset");

    // 1-word image over the 2-word one: address 1 must survive
    pulse_reload();
    check_eq("reload2_hold", 64'(cpu_hold), 64'd1);
    exp_q.push_back({8'd0, 32'h1234_5678});
    frm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    send_frame(0);
    check_run("one_word");
    check_eq("one_word_mem0", 64'(mem_model[0]), 64'h1234_5678);
    check_eq("one_word_mem1", 64'(mem_model[1]), 64'h0000_0000);
    pulse_reload();
    check_eq("reload3_hold", 64'(cpu_hold), 64'd1);
    exp_q.push_back({8'd0, 32'hABCD_EF01});
    frm = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h68};
    send_frame(0);
    check_run("overwrite");
    check_eq("overwrite_mem0", 64'(mem_model[0]), 64'hABCD_EF01);
    check_eq("overwrite_mem1", 64'(mem_model[1]), 64'h0000_0000);

    repeat (3) @(negedge clk);
    check_eq("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware counterpart of the bench-side program load: receives a byte stream, assembles big-endian 32-bit instruction words and writes them into the MIPS instruction memory from word 0.
- Holds the CPU (cpu_hold) until a complete, checksum-verified image has been written, then releases it to run.
- Sits between a byte source (UART receiver or bench driver) and the write port of the instruction memory.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.
- CNT_W, 16, width of the frame's word-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at clk edge.
- reload  input  1  single-cycle request to start a new load; honoured only in RUN or ERR.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  ADDR_W  word address.
- im_wdata  output  32  word to write.
- cpu_hold  output  1  CPU stalled (PC and register file frozen) while high.
- done  output  1  one-cycle pulse on successful load.
- err  output  1  sticky load error; cleared on reload or reset.

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4*N payload bytes (MSB first per word), then one checksum byte = sum of payload bytes mod 256. Header bytes are not summed.
- Reset values: state LEN_HI, rx_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, err=0, checksum accumulator=0, word index=0, byte index=0.
- States and transitions:
  - LEN_HI: accept byte -> LEN_LO.
  - LEN_LO: accept byte -> if N==0 or N>DEPTH then ERR, else DATA.
  - DATA: accept bytes into a shift register, adding each to the checksum. The 4th accepted byte -> WRITE.
  - WRITE: exactly one cycle with im_we=1, im_addr=word index, im_wdata=assembled word, rx_ready=0. If word index==N-1 -> CSUM; else increment word index -> DATA.
  - CSUM: accept byte -> RUN if it equals the accumulator, else ERR.
  - RUN: cpu_hold=0, rx_ready=0. done=1 for exactly the first cycle of RUN. reload -> LEN_HI, which clears the accumulator and indices and sets cpu_hold=1.
  - ERR: err=1, cpu_hold=1, rx_ready=0. reload -> LEN_HI, which clears err.
- rx_ready=1 only in LEN_HI, LEN_LO, DATA and CSUM. rx_valid gaps stall the state indefinitely without side effects.
- Latency: im_we asserts in the cycle after the 4th byte of a word is accepted.
- cpu_hold rises in the same cycle the state leaves RUN, and falls in the same cycle RUN is entered (registered outputs).
- reload while in LEN_HI..CSUM is ignored.
- Asynchronous reset mid-load returns all outputs to their reset values immediately. Already-written memory words are not cleared.
- Memory words beyond N-1 are left untouched.
- Checksum adder is 8-bit, wraps modulo 256.

Decomposition:
- Shared package holds the state encoding (LEN_HI, LEN_LO, DATA, WRITE, CSUM, RUN, ERR), the frame field constants and the ADDR_W default.
- One natural sub-module: loader_word_assembler. It contains the byte shift register, byte index and checksum accumulator, with clear, accept and word_ready outputs. The FSM stays in imem_loader.

Test Plan:
- Good load: N=2 with bytes 00 02 20 08 00 05 00 00 00 00 2D.
  - im_we pulses: addr0=0x20080005, then addr1=0x00000000.
  - done pulses once; cpu_hold falls; err=0.
- Bad checksum: same frame but trailer 2E -> both words still written, state ERR, err=1, cpu_hold stays 1, no done. Then reload plus the good frame -> normal RUN.
- Length errors:
  - N=0 (bytes 00 00) -> ERR right after LEN_LO, no im_we.
  - N=257 with ADDR_W=8 (bytes 01 01) -> ERR, no im_we.
- Backpressure and gaps: rx_valid toggled randomly, with idle gaps of 0-5 cycles within a word.
  - Identical memory contents to the good load.
  - rx_ready=0 in every WRITE cycle and no byte lost.
- Reset mid-load: assert rst_n=0 after the 6th byte of the good frame.
  - Outputs return to reset values asynchronously.
  - A fresh full frame then loads correctly.
- Reload from RUN: run a 1-word load, then reload.
  - cpu_hold=1 on the next cycle.
  - Second image overwrites address 0.
  - Address 1 from a prior 2-word load is unchanged.
